timer_apb_sequencer: RTL and testbench

//  APB master FSM that programs and services the 8-bit APB timer: loads TDR, starts the counter, polls TSR,

---
 rtl/timer_apb_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_timer_apb_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_sequencer.sv
// rtl/timer_apb_sequencer.sv - APB master sequencer that programs, polls and stops an 8-bit APB timer
//
// Purpose: on a start pulse, writes TDR, loads and enables the timer, then polls TSR,
// clears OVF/UDF flags and counts events until cfg_nevt events (or abort), then stops the timer.
//
// Optional feature macro: TSEQ_TIMEOUT_EN (ACCESS-phase timeout, handled like PSLVERR).
//
// Ports:
//   PCLK, PRESET        clock, asynchronous active-high reset
//   start, abort        request pulse (accepted in IDLE), abort level
//   cfg_tdr/mode/nevt   run configuration, latched on accepted start
//   PSEL..PWDATA        APB master request outputs
//   PRDATA/PREADY/PSLVERR APB completion inputs
//   busy, evt, evt_cnt, done, err   status to the local requester
module timer_apb_sequencer #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         POLL_GAP  = 4,
    parameter int         TIMEOUT   = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] cfg_tdr,
    input  logic [2:0] cfg_mode,
    input  logic [7:0] cfg_nevt,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output logic       busy,
    output logic       evt,
    output logic [7:0] evt_cnt,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_W_TDR  = 4'd1;
    localparam logic [3:0] S_W_LOAD = 4'd2;
    localparam logic [3:0] S_W_RUN  = 4'd3;
    localparam logic [3:0] S_R_TSR  = 4'd4;
    localparam logic [3:0] S_W_CLR  = 4'd5;
    localparam logic [3:0] S_GAP    = 4'd6;
    localparam logic [3:0] S_W_STOP = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    // With no poll gap the sequencer goes straight back to reading TSR.
    localparam logic [3:0]  S_AFTER_POLL = (POLL_GAP == 0) ? S_R_TSR : S_GAP;
    localparam logic [15:0] GAP_LOAD     = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    logic [3:0]  r_state;
    logic        r_psel;
    logic        r_penable;
    logic [7:0]  r_cfg_tdr;
    logic [2:0]  r_cfg_mode;
    logic [7:0]  r_cfg_nevt;
    logic [7:0]  r_evt_cnt;
    logic        r_evt;
    logic        r_done;
    logic        r_err;
    logic        r_abort_pend;
    logic [15:0] r_gap_cnt;

    logic        w_xfer;
    logic        w_wr;
    logic [1:0]  w_off;
    logic [7:0]  w_wdata;
    logic        w_abort;
    logic        w_last_evt;
    logic [3:0]  w_after;
    logic [5:0]  w_unused_prdata;

    assign w_unused_prdata = PRDATA[7:2];

    // Abort seen at any point of the current transfer is honoured at its completion.
    assign w_abort    = r_abort_pend | abort;
    assign w_last_evt = (r_cfg_nevt != 8'd0) &&
                        (({1'b0, r_evt_cnt} + 9'd1) == {1'b0, r_cfg_nevt});

    // Per-state transfer descriptor; held constant for the whole state, so
    // address/data are stable from SETUP through completion.
    always_comb begin
        w_xfer  = 1'b0;
        w_wr    = 1'b0;
        w_off   = 2'd0;
        w_wdata = 8'h00;
        case (r_state)
            S_W_TDR:  begin w_xfer = 1'b1; w_wr = 1'b1; w_off = 2'd1; w_wdata = r_cfg_tdr; end
            S_W_LOAD: begin w_xfer = 1'b1; w_wr = 1'b1; w_off = 2'd0;
                            w_wdata = {2'b10, r_cfg_mode[2], 1'b1, 2'b00, r_cfg_mode[1:0]}; end
            S_W_RUN:  begin w_xfer = 1'b1; w_wr = 1'b1; w_off = 2'd0;
                            w_wdata = {2'b00, r_cfg_mode[2], 1'b1, 2'b00, r_cfg_mode[1:0]}; end
            S_R_TSR:  begin w_xfer = 1'b1; w_wr = 1'b0; w_off = 2'd2; end
            S_W_CLR:  begin w_xfer = 1'b1; w_wr = 1'b1; w_off = 2'd2; end
            S_W_STOP: begin w_xfer = 1'b1; w_wr = 1'b1; w_off = 2'd0; end
            default:  ;
        endcase
    end

    // Successor state on a clean (non-error) transfer completion.
    always_comb begin
        w_after = S_IDLE;
        case (r_state)
            S_W_TDR:  w_after = w_abort ? S_W_STOP : S_W_LOAD;
            S_W_LOAD: w_after = w_abort ? S_W_STOP : S_W_RUN;
            S_W_RUN:  w_after = w_abort ? S_W_STOP : S_R_TSR;
            S_R_TSR:  w_after = w_abort ? S_W_STOP :
                                (PRDATA[1:0] != 2'b00) ? S_W_CLR : S_AFTER_POLL;
            S_W_CLR:  w_after = (w_abort || w_last_evt) ? S_W_STOP : S_AFTER_POLL;
            S_W_STOP: w_after = S_DONE;
            default:  w_after = S_IDLE;
        endcase
    end

`ifdef TSEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_to_cnt;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state      <= S_IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_cfg_tdr    <= 8'h00;
            r_cfg_mode   <= 3'b000;
            r_cfg_nevt   <= 8'h00;
            r_evt_cnt    <= 8'h00;
            r_evt        <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_gap_cnt    <= 16'd0;
`ifdef TSEQ_TIMEOUT_EN
            r_to_cnt     <= 16'd0;
`endif
        end else begin
            r_evt  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cfg_tdr    <= cfg_tdr;
                        r_cfg_mode   <= cfg_mode;
                        r_cfg_nevt   <= cfg_nevt;
                        r_evt_cnt    <= 8'h00;
                        r_abort_pend <= abort;
                        r_state      <= S_W_TDR;
                        r_psel       <= 1'b1;   // first SETUP immediately follows start
                    end
                end
                S_GAP: begin
                    if (w_abort) begin
                        r_state <= S_W_STOP;
                    end else if (r_gap_cnt == 16'd0) begin
                        r_state <= S_R_TSR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    if (r_state != S_W_STOP) begin
                        r_abort_pend <= w_abort;
                    end
                    // Entering a transfer state with PSEL low gives the idle
                    // bus cycle separating consecutive transfers.
                    if (!r_psel) begin
                        r_psel <= 1'b1;
                    end else if (!r_penable) begin
                        r_penable <= 1'b1;
`ifdef TSEQ_TIMEOUT_EN
                        r_to_cnt  <= 16'd0;
`endif
                    end else if (PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (PSLVERR) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= w_after;
                            if (r_state == S_W_CLR) begin
                                r_evt <= 1'b1;
                                if (r_evt_cnt != 8'hFF) begin
                                    r_evt_cnt <= r_evt_cnt + 8'd1;
                                end
                            end
                            if (w_after == S_GAP) begin
                                r_gap_cnt <= GAP_LOAD;
                            end
                            if (w_after == S_DONE) begin
                                r_done <= 1'b1;
                            end
                        end
`ifdef TSEQ_TIMEOUT_EN
                    end else if (r_to_cnt == TO_LAST) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
`endif
                    end
                end
            endcase
        end
    end

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = w_xfer & w_wr;
    assign PADDR   = w_xfer ? (BASE_ADDR + {6'd0, w_off}) : 8'h00;
    assign PWDATA  = (w_xfer & w_wr) ? w_wdata : 8'h00;
    assign busy    = (r_state != S_IDLE);
    assign evt     = r_evt;
    assign evt_cnt = r_evt_cnt;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// tb/tb_timer_apb_sequencer.sv - directed self-checking bench for timer_apb_sequencer
module tb_timer_apb_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       start, abort;
    logic [7:0] cfg_tdr, cfg_nevt;
    logic [2:0] cfg_mode;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic       busy, evt, done, err;
    logic [7:0] evt_cnt;

    always #5 PCLK = ~PCLK;

    timer_apb_sequencer dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start), .abort(abort),
        .cfg_tdr(cfg_tdr), .cfg_mode(cfg_mode), .cfg_nevt(cfg_nevt),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy), .evt(evt), .evt_cnt(evt_cnt), .done(done), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Slave model controls, written by the stimulus process only
    int run_id = 0;
    int stall_at = 0;
    int stall_len = 0;
    int err_at = 0;
    int rd_mode = 0;

    // Slave/monitor state, written by the monitor only
    int seen_run = 0;
    int setup_idx = 0;
    int stall_left = 0;
    int rd_ptr = 0;
    int acc_cycles = 0;
    int stab_err = 0;
    int evt_seen = 0;
    logic [7:0] cur_rd = 8'h00;
    logic [7:0] su_addr = 8'h00;
    logic [7:0] su_data = 8'h00;
    logic       su_wr = 1'b0;
    logic [16:0] xlog[$];
    int          acc_log[$];

    assign PREADY  = (stall_left == 0);
    assign PSLVERR = PSEL && PENABLE && (setup_idx == err_at);
    assign PRDATA  = cur_rd;

    always @(negedge PCLK) begin
        if (run_id != seen_run) begin
            seen_run = run_id; setup_idx = 0; rd_ptr = 0; stall_left = 0;
            acc_cycles = 0; stab_err = 0; evt_seen = 0;
            xlog.delete(); acc_log.delete();
        end
        if (!PRESET && PSEL && !PENABLE) begin
            setup_idx++;
            su_addr = PADDR; su_data = PWDATA; su_wr = PWRITE; acc_cycles = 0;
            stall_left = (setup_idx == stall_at) ? stall_len : 0;
            if (!PWRITE) begin
                // mode 0: every second TSR read shows OVF; mode 1: OVF and UDF on every read
                cur_rd = (rd_mode == 1) ? 8'h03 : ((rd_ptr % 2 == 1) ? 8'h01 : 8'h00);
                rd_ptr++;
            end
        end else if (!PRESET && PSEL && PENABLE) begin
            acc_cycles++;
            if (PADDR !== su_addr || PWRITE !== su_wr || (su_wr && PWDATA !== su_data))
                stab_err++;
            if (stall_left > 0) stall_left--;
            if (stall_left == 0) begin
                xlog.push_back({PWRITE, PADDR, PWRITE ? PWDATA : 8'h00});
                acc_log.push_back(acc_cycles);
            end
        end
        if (!PRESET && evt) evt_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_start(input logic [7:0] tdr, input logic [2:0] mode, input logic [7:0] nevt);
        run_id++;
        @(negedge PCLK);
        cfg_tdr = tdr; cfg_mode = mode; cfg_nevt = nevt; start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc, output logic err_o, output logic [7:0] cnt_o);
        logic got;
        got = 1'b0; err_o = 1'b0; cnt_o = 8'h00;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge PCLK);
            if (done) begin got = 1'b1; err_o = err; cnt_o = evt_cnt; end
        end
        check({tag, "_done_seen"}, got, 1'b1);
    endtask

    task automatic check_log(input string tag, input logic [16:0] e[$]);
        check({tag, "_nxfer"}, xlog.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            if (i < xlog.size()) check($sformatf("%s_xfer%0d", tag, i), xlog[i], e[i]);
    endtask

    initial begin
        logic        e_err;
        logic [7:0]  e_cnt;
        logic [16:0] exp_q[$];
        int          nev;

        PRESET = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_tdr = 8'h00; cfg_mode = 3'b000; cfg_nevt = 8'h00;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done_err_evt", {done, err, evt}, 3'b000);
        check("rst_evt_cnt", evt_cnt, 8'h00);

        // Two OVF events, then stop
        run_start(8'hFA, 3'b001, 8'd2);
        wait_done("t2", 500, e_err, e_cnt);
        check("t2_err", e_err, 1'b0);
        check("t2_evt_cnt", e_cnt, 8'd2);
        check("t2_evt_pulses", evt_seen, 2);
        check("t2_stable", stab_err, 0);
        exp_q = '{17'h101FA, 17'h10091, 17'h10011, 17'h00200, 17'h00200, 17'h10200,
                  17'h00200, 17'h00200, 17'h10200, 17'h10000};
        check_log("t2", exp_q);
        @(negedge PCLK);
        check("t2_idle_after", busy, 1'b0);

        // Wait states on the TDR write
        stall_at = 1; stall_len = 4;
        run_start(8'h80, 3'b100, 8'd1);
        wait_done("t3", 500, e_err, e_cnt);
        check("t3_acc0", acc_log.size() > 0 ? acc_log[0] : -1, 4);
        check("t3_acc1", acc_log.size() > 1 ? acc_log[1] : -1, 1);
        check("t3_stable", stab_err, 0);
        check("t3_evt_cnt", e_cnt, 8'd1);
        exp_q = '{17'h10180, 17'h100B0, 17'h10030, 17'h00200, 17'h00200, 17'h10200, 17'h10000};
        check_log("t3", exp_q);
        stall_at = 0; stall_len = 0;

        // Slave error on the LOAD write
        err_at = 2;
        run_start(8'h55, 3'b000, 8'd3);
        wait_done("t4", 100, e_err, e_cnt);
        check("t4_err", e_err, 1'b1);
        check("t4_busy_at_done", busy, 1'b0);
        repeat (10) @(negedge PCLK);
        check("t4_psel_quiet", PSEL, 1'b0);
        exp_q = '{17'h10155, 17'h10090};
        check_log("t4", exp_q);
        err_at = 0;

        // Free-running with abort in GAP after five events (OVF|UDF each read)
        rd_mode = 1;
        run_start(8'h10, 3'b010, 8'd0);
        nev = 0;
        for (int i = 0; i < 1000 && nev < 5; i++) begin
            @(negedge PCLK);
            if (evt) nev++;
        end
        check("t5_evt_reached", nev, 5);
        abort = 1'b1;
        wait_done("t5", 100, e_err, e_cnt);
        abort = 1'b0;
        check("t5_err", e_err, 1'b0);
        check("t5_evt_cnt", e_cnt, 8'd5);
        check("t5_nxfer", xlog.size(), 14);
        check("t5_load", xlog.size() > 1 ? xlog[1] : 17'h0, 17'h10092);
        check("t5_last_stop", xlog.size() > 0 ? xlog[xlog.size()-1] : 17'h0, 17'h10000);
        repeat (5) @(negedge PCLK);
        check("t5_evt_cnt_hold", evt_cnt, 8'd5);
        rd_mode = 0;

        // Asynchronous reset in the middle of an ACCESS phase
        stall_at = 1; stall_len = 100;
        run_start(8'h33, 3'b000, 8'd0);
        for (int i = 0; i < 10 && !(PSEL && PENABLE); i++) @(negedge PCLK);
        check("t1_in_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESET = 1'b1;
        #1;
        check("t1_psel", PSEL, 1'b0);
        check("t1_penable", PENABLE, 1'b0);
        check("t1_busy", busy, 1'b0);
        check("t1_evt_cnt", evt_cnt, 8'h00);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // PREADY stuck low
        stall_at = 1; stall_len = 1000;
        run_start(8'h44, 3'b000, 8'd0);
`ifdef TSEQ_TIMEOUT_EN
        wait_done("t6", 100, e_err, e_cnt);
        check("t6_err", e_err, 1'b1);
        check("t6_acc_cycles", acc_cycles, 16);
        check("t6_psel", PSEL, 1'b0);
`else
        repeat (100) @(negedge PCLK);
        check("t6_busy", busy, 1'b1);
        check("t6_stuck_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
`endif
        stall_at = 0; stall_len = 0;
        repeat (2) @(negedge PCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
